// File: rtl/kiscv_apb_pkg.sv
// Shared types and port indices for the two-requester APB sram arbiter.
// No logic of its own; no latency.
// No flow control here; backpressure is handled by the arbiter.
package kiscv_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_arb_state_t;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_LSU    = 1;

  // Index of the port that is not `idx` (round-robin hand-off)
  function automatic logic other_port(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/apb_sram_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the port that was not served last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only samples the pick when it can start a transfer.
module rr_pick2
  import kiscv_apb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Single requester wins outright; a tie goes to the port not served last
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'(PORT_IFETCH);
    if (req == 2'b11) begin
      gnt_idx = other_port(last);
    end else if (req[PORT_LSU]) begin
      gnt_idx = 1'(PORT_LSU);
    end
  end

endmodule

// File: rtl/apb_sram_arbiter.sv
// Shares one APB sram port between instruction fetch (port 0) and the LSU (port 1).
// Latency: rN_psel seen in IDLE at cycle N -> rN_pready at N+3 with a one-wait-state sram.
// Backpressure: the loser simply waits (its pready stays low); a hung sram is cut off by the timeout.
module apb_sram_arbiter
  import kiscv_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [ADDR_WIDTH-1:0]   r0_paddr,
  input  logic [DATA_WIDTH-1:0]   r0_pdata,
  input  logic                    r0_pwrite,
  input  logic [DATA_WIDTH/8-1:0] r0_pstb,
  input  logic                    r0_psel,
  input  logic                    r0_penable,
  output logic [DATA_WIDTH-1:0]   r0_prdata,
  output logic                    r0_pready,
  output logic                    r0_perr,
  input  logic [ADDR_WIDTH-1:0]   r1_paddr,
  input  logic [DATA_WIDTH-1:0]   r1_pdata,
  input  logic                    r1_pwrite,
  input  logic [DATA_WIDTH/8-1:0] r1_pstb,
  input  logic                    r1_psel,
  input  logic                    r1_penable,
  output logic [DATA_WIDTH-1:0]   r1_prdata,
  output logic                    r1_pready,
  output logic                    r1_perr,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pdata,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstb,
  output logic                    psel,
  output logic                    penable,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    perr
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  apb_arb_state_t  state;
  logic            grant;
  logic            last_grant;
  logic [CW-1:0]   tmo_cnt;
  logic            pick_vld;
  logic            pick_idx;
  logic            tmo_hit;
  logic            xfer_done;
  logic            rsp_err;
  logic [DATA_WIDTH-1:0] rsp_dat;

  // Requester penable carries no arbitration meaning; psel alone requests
  logic unused_penable;
  assign unused_penable = r0_penable ^ r1_penable;

  rr_pick2 u_pick (
    .req       ({r1_psel, r0_psel}),
    .last      (last_grant),
    .gnt_valid (pick_vld),
    .gnt_idx   (pick_idx)
  );

  // Completion: sram pready, or the counter having seen TIMEOUT full ACCESS cycles
  always_comb begin
    tmo_hit   = (TIMEOUT != 0) && (state == ST_ACCESS) && !pready &&
                (tmo_cnt == CW'(TIMEOUT));
    xfer_done = (state == ST_ACCESS) && (pready || tmo_hit);
    rsp_err   = pready ? perr : 1'b1;
    rsp_dat   = pready ? prdata : '0;
  end

  // Steer the response to the granted port only; the other port sees all zeros
  always_comb begin
    r0_pready = xfer_done && (grant == 1'(PORT_IFETCH));
    r1_pready = xfer_done && (grant == 1'(PORT_LSU));
    r0_perr   = r0_pready && rsp_err;
    r1_perr   = r1_pready && rsp_err;
    r0_prdata = r0_pready ? rsp_dat : '0;
    r1_prdata = r1_pready ? rsp_dat : '0;
  end

  // Transfer FSM: latches the winner's request and holds it steady until completion
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= ST_IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      paddr      <= '0;
      pdata      <= '0;
      pwrite     <= 1'b0;
      pstb       <= '0;
      grant      <= 1'(PORT_IFETCH);
      last_grant <= 1'(PORT_LSU);
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (pick_vld) begin
            grant   <= pick_idx;
            paddr   <= pick_idx ? r1_paddr  : r0_paddr;
            pdata   <= pick_idx ? r1_pdata  : r0_pdata;
            pwrite  <= pick_idx ? r1_pwrite : r0_pwrite;
            pstb    <= pick_idx ? r1_pstb   : r0_pstb;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          tmo_cnt <= '0;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (xfer_done) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            last_grant <= grant;
            tmo_cnt    <= '0;
            state      <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// Bench for apb_sram_arbiter: sram model with one wait state, reference memory and arbitration model.
// Latency expectations derived from the transfer rules (setup, access, wait state, timeout).
// Requesters hold psel until their pready, then drop it the following cycle.
module tb_apb_sram_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct packed {
    logic        act;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  stb;
  } xfer_t;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic [AW-1:0] r0_paddr, r1_paddr, paddr;
  logic [DW-1:0] r0_pdata, r1_pdata, pdata;
  logic          r0_pwrite, r1_pwrite, pwrite;
  logic [3:0]    r0_pstb, r1_pstb, pstb;
  logic          r0_psel, r1_psel, psel;
  logic          r0_penable, r1_penable, penable;
  logic [DW-1:0] r0_prdata, r1_prdata, prdata;
  logic          r0_pready, r1_pready, pready;
  logic          r0_perr, r1_perr, perr;

  int n_tests = 0;
  int n_fail  = 0;
  logic last_model = 1'b1;
  logic [31:0] ref_mem [0:63];

  always #5 pclk = ~pclk;

  apb_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .r0_paddr(r0_paddr), .r0_pdata(r0_pdata), .r0_pwrite(r0_pwrite), .r0_pstb(r0_pstb),
    .r0_psel(r0_psel), .r0_penable(r0_penable), .r0_prdata(r0_prdata), .r0_pready(r0_pready),
    .r0_perr(r0_perr),
    .r1_paddr(r1_paddr), .r1_pdata(r1_pdata), .r1_pwrite(r1_pwrite), .r1_pstb(r1_pstb),
    .r1_psel(r1_psel), .r1_penable(r1_penable), .r1_prdata(r1_prdata), .r1_pready(r1_pready),
    .r1_perr(r1_perr),
    .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .perr(perr)
  );

  // sram model: one wait state, byte-masked combinational read, error above 0xFF
  logic [31:0] sram_mem [0:63];
  logic        sram_rdy_q = 1'b0;
  logic        sram_hang = 1'b0;
  logic        stray_rdy = 1'b0;
  logic [31:0] sram_mask;
  assign sram_mask = {{8{pstb[3]}}, {8{pstb[2]}}, {8{pstb[1]}}, {8{pstb[0]}}};
  assign prdata    = sram_mem[paddr[7:2]] & sram_mask;
  assign perr      = paddr[8];
  assign pready    = sram_rdy_q | stray_rdy;

  always @(posedge pclk) begin
    sram_rdy_q <= psel && penable && !sram_rdy_q && !sram_hang;
    if (psel && penable && pready && pwrite && !paddr[8])
      for (int b = 0; b < 4; b++)
        if (pstb[b]) sram_mem[paddr[7:2]][8*b +: 8] <= pdata[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic drive(input int p, input xfer_t x, input logic sel);
    if (p == 0) begin
      r0_psel = sel; r0_penable = sel; r0_paddr = x.addr; r0_pdata = x.data;
      r0_pwrite = x.wr; r0_pstb = x.stb;
    end else begin
      r1_psel = sel; r1_penable = sel; r1_paddr = x.addr; r1_pdata = x.data;
      r1_pwrite = x.wr; r1_pstb = x.stb;
    end
  endtask

  task automatic reset_dut();
    xfer_t z;
    z = '0;
    drive(0, z, 1'b0);
    drive(1, z, 1'b0);
    presetn = 1'b0;
    @(negedge pclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pdata", pdata, 0);
    check("rst_pwrite_pstb", {pwrite, pstb}, 0);
    check("rst_rsp", {r0_pready, r0_perr, r1_pready, r1_perr}, 0);
    check("rst_prdata", r0_prdata | r1_prdata, 0);
    @(negedge pclk);
    presetn = 1'b1;
    last_model = 1'b1;
  endtask

  // Issue up to two requests in the same cycle and check every cycle until both complete
  task automatic run_pair(input xfer_t x0, input xfer_t x1, input logic hang,
                          output logic [31:0] rd0, output logic [31:0] rd1);
    xfer_t xs [2];
    int    first, second, lat, d, wp;
    int    start_s [2];
    int    exp_done [2];
    logic  pend [2];
    logic  drop [2];
    logic  exp_psel, exp_pen, rdy, er;
    logic [31:0] dat, expd;
    int    idx;
    xs[0] = x0; xs[1] = x1;
    rd0 = '0; rd1 = '0;
    sram_hang = hang;
    lat = hang ? 2 + TMO : 3;
    if (x0.act && x1.act) first = last_model ? 0 : 1;
    else first = x0.act ? 0 : 1;
    second = 1 - first;
    start_s[first] = 0;        exp_done[first] = lat;
    start_s[second] = lat + 1; exp_done[second] = 2 * lat + 1;
    pend[0] = x0.act; pend[1] = x1.act;
    @(posedge pclk); #1;
    for (int p = 0; p < 2; p++) if (xs[p].act) drive(p, xs[p], 1'b1);
    for (int o = 0; o < 40 && (pend[0] || pend[1]); o++) begin
      @(negedge pclk);
      exp_psel = 1'b0; exp_pen = 1'b0; wp = 0;
      for (int p = 0; p < 2; p++) begin
        d = o - start_s[p];
        if (xs[p].act && d >= 1 && d <= lat) begin
          exp_psel = 1'b1; exp_pen = (d >= 2); wp = p;
        end
      end
      check("psel", psel, exp_psel);
      check("penable", penable, exp_pen);
      if (exp_psel) begin
        check("paddr", paddr, xs[wp].addr);
        check("pdata", pdata, xs[wp].data);
        check("pwrite_pstb", {pwrite, pstb}, {xs[wp].wr, xs[wp].stb});
      end
      for (int p = 0; p < 2; p++) begin
        rdy = p ? r1_pready : r0_pready;
        er  = p ? r1_perr   : r0_perr;
        dat = p ? r1_prdata : r0_prdata;
        drop[p] = 1'b0;
        check(p ? "r1_pready" : "r0_pready", rdy, pend[p] && (o == exp_done[p]));
        if (rdy && pend[p]) begin
          idx  = int'(xs[p].addr[7:2]);
          expd = ref_mem[idx] & mask_of(xs[p].stb);
          check(p ? "r1_perr" : "r0_perr", er, hang ? 1'b1 : xs[p].addr[8]);
          if (!hang) check(p ? "r1_prdata" : "r0_prdata", dat, expd);
          if (p == 0) rd0 = dat; else rd1 = dat;
          if (!hang && xs[p].wr && !xs[p].addr[8])
            for (int b = 0; b < 4; b++)
              if (xs[p].stb[b]) ref_mem[idx][8*b +: 8] = xs[p].data[8*b +: 8];
          last_model = p[0];
          pend[p] = 1'b0;
          drop[p] = 1'b1;
        end else begin
          check(p ? "r1_idle_rsp" : "r0_idle_rsp", {er, dat}, 0);
        end
      end
      if (drop[0] || drop[1]) begin
        @(posedge pclk); #1;
        for (int p = 0; p < 2; p++) if (drop[p]) drive(p, xs[p], 1'b0);
      end
    end
    check("r0_done", pend[0], 0);
    check("r1_done", pend[1], 0);
    sram_hang = 1'b0;
  endtask

  function automatic xfer_t mk(input logic act, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] stb);
    xfer_t x;
    x.act = act; x.wr = wr; x.addr = addr; x.data = data; x.stb = stb;
    return x;
  endfunction

  initial begin
    xfer_t none, a, b;
    logic [31:0] d0, d1;
    logic [31:0] v;
    int k;
    none = '0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom; sram_mem[i] = v; ref_mem[i] = v;
    end
    sram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    sram_mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;

    // Single read on port 0
    reset_dut();
    run_pair(mk(1, 0, 32'h10, 0, 4'hF), none, 1'b0, d0, d1);
    check("single_rd_data", d0, 32'hDEADBEEF);

    // Contention right after reset: port 0 first, port 1 four cycles later
    reset_dut();
    run_pair(mk(1, 0, 32'h10, 0, 4'hF), mk(1, 0, 32'h20, 0, 4'hF), 1'b0, d0, d1);
    check("contend_r1_data", d1, 32'h11223344);

    // Fairness: both requesting back-to-back for eight transfers
    reset_dut();
    a = mk(1, 0, 32'h04, 0, 4'hF);
    b = mk(1, 0, 32'h08, 0, 4'hF);
    @(posedge pclk); #1;
    drive(0, a, 1'b1); drive(1, b, 1'b1);
    k = 0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      @(negedge pclk);
      if (r0_pready || r1_pready) begin
        check("fair_single", r0_pready & r1_pready, 0);
        check("fair_port", r1_pready, k % 2);
        last_model = r1_pready;
        k++;
        if (k == 8) begin
          @(posedge pclk); #1;
          drive(0, a, 1'b0); drive(1, b, 1'b0);
        end
      end
    end
    check("fair_count", k, 8);

    // Byte write from port 1, read back from port 0
    run_pair(none, mk(1, 1, 32'h20, 32'h000000AA, 4'h1), 1'b0, d0, d1);
    check("bytewr_mem", sram_mem[8], 32'h112233AA);
    run_pair(mk(1, 0, 32'h20, 0, 4'hF), none, 1'b0, d0, d1);
    check("bytewr_rd", d0, 32'h112233AA);

    // Timeout on a hung sram
    reset_dut();
    run_pair(mk(1, 0, 32'h30, 0, 4'hF), none, 1'b1, d0, d1);
    @(negedge pclk);
    check("tmo_back_idle", {psel, penable}, 0);

    // Reset mid-ACCESS, then a stray sram pready
    reset_dut();
    sram_hang = 1'b1;
    @(posedge pclk); #1;
    drive(0, mk(1, 0, 32'h10, 0, 4'hF), 1'b1);
    repeat (3) @(negedge pclk);
    check("mid_in_access", {psel, penable}, 2'b11);
    #1 presetn = 1'b0;
    #1;
    check("mid_rst_psel", {psel, penable}, 0);
    check("mid_rst_rdy", {r0_pready, r1_pready}, 0);
    drive(0, none, 1'b0);
    sram_hang = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    last_model = 1'b1;
    stray_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      check("stray_rdy", {r0_pready, r1_pready, r0_perr, r1_perr}, 0);
      check("stray_psel", psel, 0);
    end
    stray_rdy = 1'b0;
    @(negedge pclk);

    // Randomized mix of single and contending transfers
    for (int it = 0; it < 40; it++) begin
      int pat;
      pat = $urandom_range(0, 2);
      a = mk(pat != 1, 1'($urandom_range(0, 1)),
             {23'b0, ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)), 2'b00},
             $urandom, 4'($urandom_range(0, 15)));
      b = mk(pat != 0, 1'($urandom_range(0, 1)),
             {23'b0, ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)), 2'b00},
             $urandom, 4'($urandom_range(0, 15)));
      run_pair(a, b, 1'b0, d0, d1);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
